// File: rtl/route_sched.sv
// Route scheduler: queues destination IDs from the host link and walks the command
// controller through them one leg at a time (GO, wait for arrival, dwell, next GO).
module route_sched #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DWELL_CYC = 25_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   host_cmd,
  input  logic                         host_rdy,
  output logic                         host_clr,
  output logic [7:0]                   cmd,
  output logic                         cmd_rdy,
  input  logic                         clr_cmd_rdy,
  input  logic                         in_transit,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   q_cnt,
  output logic [5:0]                   cur_dest,
  output logic                         route_done,
  output logic                         ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = $clog2(DWELL_CYC + 1);
  localparam logic [DW-1:0] DwellLoad = DW'(DWELL_CYC - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIssue  = 3'd1;
  localparam logic [2:0] StTravel = 3'd2;
  localparam logic [2:0] StDwell  = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          host_clr_q, host_clr_d;
  logic          busy_q, busy_d;
  logic [5:0]    cur_dest_q, cur_dest_d;
  logic          route_done_q, route_done_d;
  logic          ovf_q, ovf_d;
  logic          abort_pend_q, abort_pend_d;
  logic          seen_high_q, seen_high_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [5:0]    mem_q [DEPTH];
  logic [5:0]    mem_d [DEPTH];

  logic consume, is_enq, is_start, is_abort, ack, pop, pop_ok, push, arrived;
  logic [5:0] head;

  assign consume  = host_rdy & ~host_clr_q;
  assign is_enq   = consume & (host_cmd[7:6] == 2'b10);
  assign is_start = consume & (host_cmd[7:6] == 2'b11);
  assign is_abort = consume & (host_cmd[7:6] == 2'b00);
  assign ack      = cmd_rdy_q & clr_cmd_rdy;
  assign arrived  = ~in_transit & seen_high_q;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_rdy_d    = cmd_rdy_q;
    cur_dest_d   = cur_dest_q;
    abort_pend_d = abort_pend_q;
    seen_high_d  = seen_high_q;
    dwell_d      = dwell_q;
    route_done_d = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_start && cnt_q != '0) begin
          state_d   = StIssue;
          cmd_d     = {2'b01, head};
          cmd_rdy_d = 1'b1;
        end
      end
      StIssue: begin
        if (is_abort) abort_pend_d = 1'b1;
        if (ack) begin
          cmd_rdy_d   = 1'b0;
          pop         = 1'b1;
          cur_dest_d  = cmd_q[5:0];
          seen_high_d = 1'b0;
          state_d     = (abort_pend_q | is_abort) ? StStop : StTravel;
        end
      end
      StTravel: begin
        seen_high_d = seen_high_q | in_transit;
        if (arrived) begin
          // Arrival beats a same-cycle abort: robot is already stopped, no STOP needed.
          if (is_abort) begin
            state_d = StIdle;
          end else begin
            dwell_d = DwellLoad;
            state_d = StDwell;
          end
        end else if (is_abort) begin
          state_d   = StStop;
          cmd_d     = 8'h00;
          cmd_rdy_d = 1'b1;
        end
      end
      StDwell: begin
        if (is_abort) begin
          state_d = StIdle;
        end else if (dwell_q == '0) begin
          if (cnt_q == '0) begin
            route_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            state_d   = StIssue;
            cmd_d     = {2'b01, head};
            cmd_rdy_d = 1'b1;
          end
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      StStop: begin
        // Entered from ISSUE with cmd_rdy low so the STOP is a distinct handshake.
        if (!cmd_rdy_q) begin
          cmd_d     = 8'h00;
          cmd_rdy_d = 1'b1;
        end else if (ack) begin
          cmd_rdy_d    = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d     = (state_d != StIdle);
    host_clr_d = consume;
  end

  // Queue bookkeeping; an abort flush overrides any same-cycle pop.
  always_comb begin
    pop_ok   = pop & (cnt_q != '0) & ~is_abort;
    push     = is_enq & ((cnt_q != CW'(DEPTH)) | pop_ok);
    ovf_d    = is_enq & ~push;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop_ok);
    if (push) begin
      mem_d[wr_ptr_q] = host_cmd[5:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (is_abort) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      host_clr_q   <= 1'b0;
      busy_q       <= 1'b0;
      cur_dest_q   <= '0;
      route_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      seen_high_q  <= 1'b0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      host_clr_q   <= host_clr_d;
      busy_q       <= busy_d;
      cur_dest_q   <= cur_dest_d;
      route_done_q <= route_done_d;
      ovf_q        <= ovf_d;
      abort_pend_q <= abort_pend_d;
      seen_high_q  <= seen_high_d;
      dwell_q      <= dwell_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign host_clr   = host_clr_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign busy       = busy_q;
  assign q_cnt      = cnt_q;
  assign cur_dest   = cur_dest_q;
  assign route_done = route_done_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_route_sched.sv
// Randomized bench for route_sched: a queue-based scoreboard predicts leg order,
// queue occupancy, overflow, and the dwell/route_done timing.
module tb_route_sched;
  localparam int DEPTH = 8;
  localparam int DWELL = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] host_cmd = 8'h00;
  logic       host_rdy = 1'b0;
  logic       clr_cmd_rdy = 1'b0;
  logic       in_transit = 1'b0;
  logic       host_clr, cmd_rdy, busy, route_done, ovf;
  logic [7:0] cmd;
  logic [3:0] q_cnt;
  logic [5:0] cur_dest;

  route_sched #(.DEPTH(DEPTH), .DWELL_CYC(DWELL)) dut (
    .clk(clk), .rst(rst), .host_cmd(host_cmd), .host_rdy(host_rdy), .host_clr(host_clr),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .in_transit(in_transit),
    .busy(busy), .q_cnt(q_cnt), .cur_dest(cur_dest), .route_done(route_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_pulses = 0;
  logic [5:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (route_done) rd_pulses <= rd_pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output logic got_ovf);
    int guard = 0;
    while (host_clr && guard < 4) begin
      tick();
      guard++;
    end
    host_cmd = b;
    host_rdy = 1'b1;
    tick();
    host_rdy = 1'b0;
    got_ovf  = ovf;
    check("host_clr", host_clr, 1);
  endtask

  task automatic enq(input logic [5:0] id);
    logic o;
    bit full;
    full = (exp_q.size() >= DEPTH);
    send({2'b10, id}, o);
    check("ovf", o, full);
    if (!full) exp_q.push_back(id);
  endtask

  task automatic start();
    logic o;
    send(8'hC0, o);
  endtask

  task automatic abort();
    logic o;
    send(8'h00, o);
    exp_q.delete();
  endtask

  task automatic wait_rdy(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (cmd_rdy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("cmd_rdy_timeout", 0, 1);
  endtask

  task automatic ack_cmd();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  // One leg: check the GO, acknowledge after ack_dly, travel tr_len cycles; arr = arrival cycle.
  task automatic do_leg(input int ack_dly, input int tr_len, input bit has_extra,
                        input logic [5:0] extra, output int arr);
    bit ok;
    logic [5:0] id;
    wait_rdy(40, ok);
    id = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
    check("go_cmd", cmd, {2'b01, id});
    check("busy_leg", busy, 1);
    repeat (ack_dly) tick();
    check("go_hold", {cmd_rdy, cmd}, {1'b1, 2'b01, id});
    ack_cmd();
    check("rdy_drop", cmd_rdy, 0);
    check("cur_dest", cur_dest, id);
    check("q_cnt_leg", q_cnt, exp_q.size());
    in_transit = 1'b1;
    if (has_extra) enq(extra);
    repeat (tr_len) tick();
    in_transit = 1'b0;
    tick();
    arr = cyc;
  endtask

  task automatic run_route(input int ack_lo, input int ack_hi, input int tr_lo, input int tr_hi,
                           input bit has_extra, input logic [5:0] extra);
    int arr, rd0;
    bit ok, first;
    rd0   = rd_pulses;
    first = 1'b1;
    do begin
      do_leg($urandom_range(ack_lo, ack_hi), $urandom_range(tr_lo, tr_hi),
             first && has_extra, extra, arr);
      first = 1'b0;
      if (exp_q.size() > 0) begin
        wait_rdy(40, ok);
        check("dwell_gap", cyc - arr, DWELL);
      end else begin
        for (int i = 0; i < 40 && !route_done; i++) tick();
        check("done_gap", cyc - arr, DWELL);
        check("q_cnt_end", q_cnt, 0);
      end
    end while (exp_q.size() > 0);
    tick();
    check("done_once", rd_pulses - rd0, 1);
    check("busy_end", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hc_m;
    bit ok;
    int rd0;
    logic [5:0] id;

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    check("rst_outs", {cmd_rdy, busy, host_clr, route_done, ovf, cmd, q_cnt, cur_dest}, 0);

    // Held host_rdy: one consume per host_clr-low cycle, one push per consume
    hc_m = 1'b0;
    host_cmd = {2'b10, 6'h07};
    host_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hc_m = !hc_m;
      if (hc_m) exp_q.push_back(6'h07);
      tick();
      check("hs_clr", host_clr, hc_m);
      check("hs_cnt", q_cnt, exp_q.size());
    end
    host_rdy = 1'b0;
    tick();
    check("hs_clr_idle", host_clr, 0);
    abort();
    check("flush_idle", q_cnt, 0);
    start();
    repeat (3) begin
      check("empty_start", {busy, cmd_rdy}, 0);
      tick();
    end

    // Two-leg route with fixed timing
    enq(6'h05);
    enq(6'h12);
    start();
    run_route(3, 3, 10, 10, 1'b0, 6'h00);

    // Overflow and pointer wrap
    for (int i = 1; i <= 9; i++) enq(6'(i));
    check("q_full", q_cnt, DEPTH);
    start();
    run_route(0, 3, 1, 8, 1'b1, 6'h0A);

    // Reset in the middle of ISSUE
    enq(6'h21);
    enq(6'h22);
    start();
    wait_rdy(10, ok);
    rst = 1'b1;
    tick();
    tick();
    check("rst_mid", {cmd_rdy, busy, host_clr, q_cnt}, 0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("rst_after", {cmd_rdy, busy, host_clr, q_cnt}, 0);

    // ABORT during TRAVEL with queued legs
    rd0 = rd_pulses;
    for (int i = 0; i < 3; i++) enq(6'($urandom_range(0, 63)));
    start();
    wait_rdy(10, ok);
    id = exp_q.pop_front();
    check("tr_go", cmd, {2'b01, id});
    ack_cmd();
    in_transit = 1'b1;
    tick();
    abort();
    wait_rdy(10, ok);
    check("tr_stop", cmd, 8'h00);
    check("tr_flush", q_cnt, 0);
    repeat (2) tick();
    check("tr_stop_hold", {cmd_rdy, cmd}, 9'h100);
    ack_cmd();
    check("tr_idle", {busy, cmd_rdy}, 0);
    in_transit = 1'b0;
    repeat (20) tick();
    check("tr_no_done", rd_pulses - rd0, 0);

    // ABORT while a GO awaits its acknowledge
    rd0 = rd_pulses;
    enq(6'h0C);
    enq(6'h0D);
    start();
    wait_rdy(10, ok);
    id = exp_q[0];
    abort();
    repeat (4) tick();
    check("is_hold", {cmd_rdy, cmd}, {1'b1, 2'b01, id});
    check("is_flush", q_cnt, 0);
    ack_cmd();
    check("is_gap", cmd_rdy, 0);
    check("is_dest", cur_dest, id);
    wait_rdy(10, ok);
    check("is_stop", {cmd, busy}, {8'h00, 1'b1});
    ack_cmd();
    check("is_idle", {busy, cmd_rdy}, 0);
    repeat (20) tick();
    check("is_no_done", rd_pulses - rd0, 0);

    // Randomized routes
    for (int r = 0; r < 4; r++) begin
      int n;
      bit xtra;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) enq(6'($urandom_range(0, 63)));
      check("rnd_cnt", q_cnt, n);
      start();
      xtra = 1'($urandom_range(0, 1));
      run_route(0, 4, 1, 12, xtra, 6'($urandom_range(0, 63)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
